fetch_stage: RTL
================

Name: fetch_stage

Overview:
Parametrised instruction-fetch stage for the pipelined core; successor to the single-cycle PC/next-PC logic. Owns the PC register, drives the instruction-memory address, and registers the IF/ID pipeline latch with stall, flush and redirect control. Contains a halt FSM that drains the pipeline after an EBREAK and asserts halted, unless an older redirect cancels it.

Parameters:
XLEN, 32, PC and address width
ILEN, 32, instruction width
RESET_PC, 0, PC value loaded on reset
NOP, 32'h00000013, instruction inserted on bubble/flush (addi x0,x0,0)
DRAIN_CYCLES, 4, cycles spent in DRAIN before entering HALTED (pipeline depth minus 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC and IF/ID contents (load-use hazard)
flush  in  1  squash IF/ID to bubble on next edge
redirect  in  1  load redirect_pc into PC on next edge (taken branch/JAL/JALR)
redirect_pc  in  XLEN  redirect target
imem_addr  out  XLEN  current PC, to combinational InstMem
imem_data  in  ILEN  instruction at imem_addr, same cycle
ifid_pc  out  XLEN  PC of latched instruction
ifid_pc4  out  XLEN  ifid_pc + 4
ifid_inst  out  ILEN  latched instruction
ifid_valid  out  1  latched instruction is real (not a bubble)
halted  out  1  core halted, sticky until reset

Behaviour:
- Reset (async): PC=RESET_PC, ifid_pc=0, ifid_pc4=0, ifid_inst=NOP, ifid_valid=0, halted=0, state=RUN, drain counter=0.
- imem_addr = PC combinationally; fetch latency 1 cycle (instruction appears on ifid_* the edge after its PC is presented).
- EBREAK detect: imem_data[6:0]==7'b1110011 and imem_data[20]==1.
- Next PC priority: redirect > halt hold > stall > PC+4. Redirect loads {redirect_pc[XLEN-1:1],1'b0}. PC+4 wraps modulo 2^XLEN.
- IF/ID priority: flush or redirect -> bubble (ifid_inst=NOP, ifid_valid=0, pc fields unchanged); else stall -> hold; else latch PC, PC+4, imem_data, valid=1 (valid=0 in DRAIN/HALTED).
- States:
  RUN: normal. EBREAK fetched, no stall/redirect/flush -> EBREAK latched into IF/ID with valid=1, PC holds at EBREAK address, counter=0, -> DRAIN.
  DRAIN: PC held; IF/ID takes bubbles. Counter increments each cycle. redirect -> PC=target, -> RUN (EBREAK was wrong-path). Counter reaches DRAIN_CYCLES-1 with no redirect -> HALTED.
  HALTED: halted=1, PC frozen, IF/ID bubbles; stall/flush/redirect ignored; only rst exits.
- Stall during DRAIN does not pause the counter. EBREAK seen while stall=1 is not acted on until stall deasserts.
- Simultaneous flush and stall: flush wins. Simultaneous redirect and EBREAK fetch: redirect wins, no DRAIN entry.
- Reset mid-DRAIN: returns to RUN at RESET_PC, halted=0.
- Counter width: $clog2(DRAIN_CYCLES+1); DRAIN_CYCLES>=1 required.

Decomposition:
- Shared package/defines: SYSTEM opcode 7'b1110011, NOP encoding, halt-FSM state encodings (RUN, DRAIN, HALTED), IR field macros already in defines.
- One sub-module: pipe_reg (WIDTH, RESET_VAL params; en, clr inputs; async active-high rst), instantiated for PC and each IF/ID field.

Test Plan:
- Reset release, RESET_PC=0, stall/flush/redirect=0 -> imem_addr 0,4,8,12 on successive cycles; ifid_pc lags by one; ifid_valid=1 from the first edge after reset.
- stall=1 for 2 cycles while PC=8 -> imem_addr stays 8, ifid_pc stays 4, ifid_inst unchanged; resumes at 12.
- redirect=1, redirect_pc=0x41 at PC=0x10 -> next imem_addr=0x40, ifid_valid=0, ifid_inst=NOP for that cycle.
- EBREAK (0x00100073) at PC=0x20, DRAIN_CYCLES=4 -> imem_addr held 0x20, 4 bubble cycles, halted=1 and stays 1 with further redirect pulses.
- EBREAK at 0x20, redirect to 0x100 in the second DRAIN cycle -> halted stays 0, state RUN, imem_addr=0x100.
- XLEN=32, redirect to 0xFFFFFFFC -> next PC wraps to 0x00000000; rst asserted mid-DRAIN -> immediate RUN, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: SYSTEM opcode, NOP and
// halt-FSM state encodings.
package fetch_stage_pkg;

    // Major opcode of SYSTEM instructions (ECALL/EBREAK/CSR*)
    localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;

    // addi x0,x0,0 - the canonical bubble instruction
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // Bit that separates EBREAK (1) from ECALL (0) in the immediate field
    localparam int EBREAK_BIT = 20;

    // Halt FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register with load enable and synchronous clear to the
// reset value. Clear has priority over load.
module pipe_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);

    // Storage: async reset, clear to RESET_VAL, otherwise load when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID
// latch with stall/flush/redirect, and a halt FSM that drains the pipeline
// after an EBREAK before asserting halted.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               ILEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter logic [ILEN-1:0]  NOP          = ILEN'(NOP_INST),
    parameter int               DRAIN_CYCLES = 4   // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [ILEN-1:0]  imem_data,
    output logic [XLEN-1:0]  ifid_pc,
    output logic [XLEN-1:0]  ifid_pc4,
    output logic [ILEN-1:0]  ifid_inst,
    output logic             ifid_valid,
    output logic             halted
);

    localparam int             CW       = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DRAIN_CYCLES - 1);

    halt_state_t      state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pc_target;
    logic [XLEN-1:0]  pc_d;
    logic             pc_en;
    logic             ifid_load;
    logic             ifid_bubble;
    logic             is_ebreak;

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    // Branch targets are halfword aligned: force bit 0 low
    assign pc_target = redirect_pc & ~XLEN'(1);
    assign is_ebreak = (imem_data[6:0] == SYSTEM_OPCODE) && imem_data[EBREAK_BIT];
    assign halted    = (state_reg == ST_HALTED);

    // Halt FSM state and drain counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, next-PC and IF/ID control
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_en       = 1'b0;
        pc_d        = pc_plus4;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (redirect) begin
                    pc_en       = 1'b1;
                    pc_d        = pc_target;
                    ifid_bubble = 1'b1;
                end else if (is_ebreak && !stall && !flush) begin
                    // Latch the EBREAK itself, freeze the PC and start draining
                    ifid_load  = 1'b1;
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    pc_en = !stall;
                    if (flush) begin
                        ifid_bubble = 1'b1;
                    end else if (!stall) begin
                        ifid_load = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                ifid_bubble = 1'b1;
                if (redirect) begin
                    // An older branch resolved: the EBREAK was wrong-path
                    pc_en      = 1'b1;
                    pc_d       = pc_target;
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    pipe_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .clr(1'b0), .d(pc_d), .q(pc)
    );

    pipe_reg #(.WIDTH(XLEN), .RESET_VAL('0)) u_ifid_pc (
        .clk(clk), .rst(rst), .en(ifid_load), .clr(1'b0), .d(pc), .q(ifid_pc)
    );

    pipe_reg #(.WIDTH(XLEN), .RESET_VAL('0)) u_ifid_pc4 (
        .clk(clk), .rst(rst), .en(ifid_load), .clr(1'b0), .d(pc_plus4), .q(ifid_pc4)
    );

    pipe_reg #(.WIDTH(ILEN), .RESET_VAL(NOP)) u_ifid_inst (
        .clk(clk), .rst(rst), .en(ifid_load), .clr(ifid_bubble), .d(imem_data), .q(ifid_inst)
    );

    pipe_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_ifid_valid (
        .clk(clk), .rst(rst), .en(ifid_load), .clr(ifid_bubble), .d(1'b1), .q(ifid_valid)
    );

endmodule
